// File: rtl/fetch_queue_pkg.sv
// Shared core package for the fetch queue.
//   FETCH_WIDTH  : core fetch/decode width (slots per cycle)
//   QUEUE_DEPTH  : core default queue depth
//   fq_idx_t     : queue index type for the core default depth
//   fetch_slot_t : one fetched instruction {pc, instr}
package fetch_queue_pkg;

  localparam int FETCH_WIDTH = 2;
  localparam int QUEUE_DEPTH = 8;

  typedef logic [$clog2(QUEUE_DEPTH)-1:0] fq_idx_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_slot_t;

endpackage

// File: rtl/fq_compactor.sv
// Valid-slot compactor: packs the valid slots of a fetch group into
// ascending order starting at position 0 and reports how many there are.
// Ports:
//   in_valid  [FETCH_WIDTH]   per-slot valid of the incoming group
//   in_slots  [FETCH_WIDTH]   incoming {pc, instr} per slot
//   out_slots [FETCH_WIDTH]   compacted slots; entries >= count are zero
//   count                     popcount(in_valid)
module fq_compactor #(
  parameter int FETCH_WIDTH = 2,
  localparam int CNT_W = $clog2(FETCH_WIDTH + 1)
) (
  input  logic [FETCH_WIDTH-1:0]                        in_valid,
  input  fetch_queue_pkg::fetch_slot_t [FETCH_WIDTH-1:0] in_slots,
  output fetch_queue_pkg::fetch_slot_t [FETCH_WIDTH-1:0] out_slots,
  output logic [CNT_W-1:0]                              count
);
  import fetch_queue_pkg::*;

  // prefix[i] = number of valid slots below slot i = destination of slot i
  logic [FETCH_WIDTH-1:0][CNT_W-1:0] prefix;

  // NOTE: always_comb uses blocking '=' and assigns every output a default
  // first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    prefix = '0;
    count  = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      prefix[i] = count;
      if (in_valid[i]) count = count + 1'b1;
    end
  end

  // Output j takes the one valid slot whose destination is j.
  always_comb begin
    out_slots = '0;
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (in_valid[i] && prefix[i] == CNT_W'(j)) out_slots[j] = in_slots[i];
      end
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue between instruction fetch and decode. Accepts a whole fetch
// group (compacted valid slots) when FETCH_WIDTH entries are free, and
// presents the oldest FETCH_WIDTH entries to decode, which consumes the
// longest ready prefix. Flush drops everything, queued and incoming.
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   flush                    branch-misprediction flush
//   in_valid/in_pc/in_instr  fetch group (per slot)
//   in_ready                 whole group is accepted this cycle
//   out_valid/out_pc/out_instr  head+k entries presented to decode
//   deq_ready                decode can take slot k
//   occupancy                number of valid entries
module fetch_queue #(
  parameter int FETCH_WIDTH = fetch_queue_pkg::FETCH_WIDTH,
  parameter int DEPTH       = fetch_queue_pkg::QUEUE_DEPTH,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [FETCH_WIDTH-1:0]        in_valid,
  input  logic [FETCH_WIDTH-1:0][31:0]  in_pc,
  input  logic [FETCH_WIDTH-1:0][31:0]  in_instr,
  output logic                          in_ready,
  output logic [FETCH_WIDTH-1:0]        out_valid,
  output logic [FETCH_WIDTH-1:0][31:0]  out_pc,
  output logic [FETCH_WIDTH-1:0][31:0]  out_instr,
  input  logic [FETCH_WIDTH-1:0]        deq_ready,
  output logic [OCC_W-1:0]              occupancy
);
  import fetch_queue_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(FETCH_WIDTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;

  fetch_slot_t [FETCH_WIDTH-1:0] in_slots;
  fetch_slot_t [FETCH_WIDTH-1:0] comp_slots;
  logic [CNT_W-1:0]              enq_cnt;
  logic [CNT_W-1:0]              deq_cnt;
  logic                          enq_en;
  logic                          refused;

  ptr_t        head;
  ptr_t        tail;
  fetch_slot_t mem [DEPTH];

  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      in_slots[i].pc    = in_pc[i];
      in_slots[i].instr = in_instr[i];
    end
  end

  fq_compactor #(.FETCH_WIDTH(FETCH_WIDTH)) u_compactor (
    .in_valid  (in_valid),
    .in_slots  (in_slots),
    .out_slots (comp_slots),
    .count     (enq_cnt)
  );

  // Credit comes from the registered count only; a same-cycle dequeue does
  // not open room, keeping in_ready free of any path from deq_ready.
  assign in_ready = (OCC_W'(DEPTH) - occupancy) >= OCC_W'(FETCH_WIDTH);
  assign enq_en   = in_ready && !flush;

  always_comb begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      out_valid[k] = occupancy > OCC_W'(k);
      out_pc[k]    = mem[head + ptr_t'(k)].pc;
      out_instr[k] = mem[head + ptr_t'(k)].instr;
    end
  end

  // Decode consumes in order: stop counting at the first slot it refuses.
  always_comb begin
    deq_cnt = '0;
    refused = 1'b0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (!refused && out_valid[k] && deq_ready[k]) deq_cnt = deq_cnt + 1'b1;
      else                                          refused = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else begin
      head      <= head + ptr_t'(deq_cnt);
      tail      <= tail + (enq_en ? ptr_t'(enq_cnt) : '0);
      occupancy <= occupancy + (enq_en ? OCC_W'(enq_cnt) : '0) - OCC_W'(deq_cnt);
    end
  end

  // NOTE: payload storage has no reset (and is not cleared on flush); its
  // contents only matter where out_valid is set, so it maps to plain RAM.
  always_ff @(posedge clk) begin
    if (enq_en) begin
      for (int j = 0; j < FETCH_WIDTH; j++) begin
        if (CNT_W'(j) < enq_cnt) mem[tail + ptr_t'(j)] <= comp_slots[j];
      end
    end
  end

  assert property (@(posedge clk) disable iff (reset) occupancy <= OCC_W'(DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (FETCH_WIDTH=2, DEPTH=8): a table of
// directed vectors plus hand-written wrap and asynchronous-reset sequences.
module tb_fetch_queue;

  logic              clk;
  logic              reset;
  logic              flush;
  logic [1:0]        in_valid;
  logic [1:0][31:0]  in_pc;
  logic [1:0][31:0]  in_instr;
  logic              in_ready;
  logic [1:0]        out_valid;
  logic [1:0][31:0]  out_pc;
  logic [1:0][31:0]  out_instr;
  logic [1:0]        deq_ready;
  logic [3:0]        occupancy;

  int checks = 0;
  int errors = 0;

  fetch_queue #(.FETCH_WIDTH(2), .DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .deq_ready (deq_ready),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        fl;
    logic [1:0]  iv;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic [1:0]  dr;
    logic [3:0]  occ;
    logic [1:0]  ov;
    logic        rdy;
    logic [31:0] opc0;
    logic [31:0] opc1;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs; instr words are ~pc so payload pairing is checked.
  task automatic step(input logic fl, input logic [1:0] iv, input logic [31:0] p0,
                      input logic [31:0] p1, input logic [1:0] dr);
    flush       = fl;
    in_valid    = iv;
    in_pc[0]    = p0;
    in_pc[1]    = p1;
    in_instr[0] = ~p0;
    in_instr[1] = ~p1;
    deq_ready   = dr;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [3:0] occ, input logic [1:0] ov,
                              input logic rdy, input logic [31:0] p0, input logic [31:0] p1);
    check({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    check({tag, ".in_ready"},  32'(in_ready),  32'(rdy));
    if (ov[0]) begin
      check({tag, ".out_pc0"},    out_pc[0],    p0);
      check({tag, ".out_instr0"}, out_instr[0], ~p0);
    end
    if (ov[1]) begin
      check({tag, ".out_pc1"},    out_pc[1],    p1);
      check({tag, ".out_instr1"}, out_instr[1], ~p1);
    end
  endtask

  initial begin
    //          fl  iv     pc0       pc1       dr     occ   ov     rdy   opc0      opc1
    // Fill to full, no dequeue: 2,4,6,8 then in_ready drops.
    vecs[0]  = '{1'b0, 2'b11, 32'h10,  32'h14,  2'b00, 4'd2, 2'b11, 1'b1, 32'h10,  32'h14};
    vecs[1]  = '{1'b0, 2'b11, 32'h18,  32'h1C,  2'b00, 4'd4, 2'b11, 1'b1, 32'h10,  32'h14};
    vecs[2]  = '{1'b0, 2'b11, 32'h20,  32'h24,  2'b00, 4'd6, 2'b11, 1'b1, 32'h10,  32'h14};
    vecs[3]  = '{1'b0, 2'b11, 32'h28,  32'h2C,  2'b00, 4'd8, 2'b11, 1'b0, 32'h10,  32'h14};
    // Full: offered group is ignored.
    vecs[4]  = '{1'b0, 2'b11, 32'h90,  32'h94,  2'b00, 4'd8, 2'b11, 1'b0, 32'h10,  32'h14};
    // Drain two; then simultaneous enqueue+dequeue (tail wraps to 0).
    vecs[5]  = '{1'b0, 2'b00, 32'h0,   32'h0,   2'b11, 4'd6, 2'b11, 1'b1, 32'h18,  32'h1C};
    vecs[6]  = '{1'b0, 2'b11, 32'h30,  32'h34,  2'b11, 4'd6, 2'b11, 1'b1, 32'h20,  32'h24};
    vecs[7]  = '{1'b0, 2'b00, 32'h0,   32'h0,   2'b01, 4'd5, 2'b11, 1'b1, 32'h24,  32'h28};
    // Flush at occupancy 5 beats enqueue and dequeue.
    vecs[8]  = '{1'b1, 2'b11, 32'h40,  32'h44,  2'b11, 4'd0, 2'b00, 1'b1, 32'h0,   32'h0};
    // Compaction of non-prefix pattern 2'b10.
    vecs[9]  = '{1'b0, 2'b10, 32'h100, 32'h104, 2'b00, 4'd1, 2'b01, 1'b1, 32'h104, 32'h0};
    vecs[10] = '{1'b0, 2'b01, 32'h108, 32'h10,  2'b00, 4'd2, 2'b11, 1'b1, 32'h104, 32'h108};
    // All-zero valid enqueues nothing.
    vecs[11] = '{1'b0, 2'b00, 32'h50,  32'h54,  2'b00, 4'd2, 2'b11, 1'b1, 32'h104, 32'h108};
    vecs[12] = '{1'b0, 2'b01, 32'h10C, 32'h0,   2'b00, 4'd3, 2'b11, 1'b1, 32'h104, 32'h108};
    // Partial dequeue: slot 0 refused blocks slot 1; then exactly one leaves.
    vecs[13] = '{1'b0, 2'b00, 32'h0,   32'h0,   2'b10, 4'd3, 2'b11, 1'b1, 32'h104, 32'h108};
    vecs[14] = '{1'b0, 2'b00, 32'h0,   32'h0,   2'b01, 4'd2, 2'b11, 1'b1, 32'h108, 32'h10C};

    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = '0;
    in_pc     = '0;
    in_instr  = '0;
    deq_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    expect_state("reset", 4'd0, 2'b00, 1'b1, 32'h0, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].fl, vecs[i].iv, vecs[i].pc0, vecs[i].pc1, vecs[i].dr);
      expect_state($sformatf("vec%0d", i), vecs[i].occ, vecs[i].ov, vecs[i].rdy,
                   vecs[i].opc0, vecs[i].opc1);
    end

    // Wrap: walk head and tail to 7, then enqueue a group across the wrap.
    step(1'b1, 2'b00, 32'h0,   32'h0,   2'b00);
    step(1'b0, 2'b11, 32'h300, 32'h304, 2'b00);
    step(1'b0, 2'b11, 32'h308, 32'h30C, 2'b11);
    step(1'b0, 2'b11, 32'h310, 32'h314, 2'b11);
    step(1'b0, 2'b01, 32'h318, 32'h0,   2'b11);
    step(1'b0, 2'b00, 32'h0,   32'h0,   2'b01);
    expect_state("wrap_empty", 4'd0, 2'b00, 1'b1, 32'h0, 32'h0);
    step(1'b0, 2'b11, 32'h200, 32'h204, 2'b00);
    expect_state("wrap_fill", 4'd2, 2'b11, 1'b1, 32'h200, 32'h204);
    check("wrap_mem7", dut.mem[7].pc, 32'h200);
    check("wrap_mem0", dut.mem[0].pc, 32'h204);
    step(1'b0, 2'b00, 32'h0, 32'h0, 2'b01);
    expect_state("wrap_deq1", 4'd1, 2'b01, 1'b1, 32'h204, 32'h0);
    step(1'b0, 2'b00, 32'h0, 32'h0, 2'b01);
    expect_state("wrap_deq2", 4'd0, 2'b00, 1'b1, 32'h0, 32'h0);

    // Asynchronous reset mid-cycle at occupancy 6.
    step(1'b0, 2'b11, 32'h500, 32'h504, 2'b00);
    step(1'b0, 2'b11, 32'h508, 32'h50C, 2'b00);
    step(1'b0, 2'b11, 32'h510, 32'h514, 2'b00);
    expect_state("pre_reset", 4'd6, 2'b11, 1'b1, 32'h500, 32'h504);
    #2;
    reset = 1'b1;
    #1;
    expect_state("async_reset", 4'd0, 2'b00, 1'b1, 32'h0, 32'h0);
    in_valid  = 2'b00;
    deq_ready = 2'b00;
    @(posedge clk);
    #1;
    expect_state("held_reset", 4'd0, 2'b00, 1'b1, 32'h0, 32'h0);
    reset = 1'b0;
    step(1'b0, 2'b01, 32'h400, 32'h0, 2'b00);
    expect_state("post_reset", 4'd1, 2'b01, 1'b1, 32'h400, 32'h0);

    in_valid  = '0;
    deq_ready = '0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
